// File: rtl/imem_loader_if.sv
// Control, byte-stream and instruction-memory write signals of the loader.
// The master side drives requests and the byte stream; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       checksum;

  modport master (
    output start, base_addr, word_count, abort, s_data, s_valid,
    input  s_ready, mem_we, mem_addr, mem_wdata, busy, done, error, checksum
  );

  modport slave (
    input  start, base_addr, word_count, abort, s_data, s_valid,
    output s_ready, mem_we, mem_addr, mem_wdata, busy, done, error, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses, keeping an XOR checksum.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       lo_bytes;
  logic [ADDR_W+1:0] end_addr;
  logic              xfer;

  // Range check is done two bits wider than the address so it can never wrap.
  assign end_addr = {2'b00, bus.base_addr} + {1'b0, bus.word_count};

  assign bus.s_ready = (state == COLLECT);
  assign bus.mem_we  = (state == WRITE);
  assign bus.busy    = (state != IDLE);
  assign xfer        = bus.s_valid && (state == COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base_q        <= '0;
      count_q       <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      lo_bytes      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.checksum  <= '0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            base_q       <= bus.base_addr;
            count_q      <= bus.word_count;
            word_idx     <= '0;
            byte_idx     <= '0;
            bus.checksum <= '0;
            if (bus.word_count == '0)   state     <= FINISH;
            else if (end_addr > DEPTH_W) bus.error <= 1'b1;
            else                         state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (xfer) begin
            if (byte_idx == 2'd3) begin
              // Address/data only move when a write is actually about to happen.
              bus.mem_wdata <= {bus.s_data, lo_bytes};
              bus.mem_addr  <= base_q + word_idx[ADDR_W-1:0];
              byte_idx      <= '0;
              state         <= WRITE;
            end else begin
              lo_bytes[8*byte_idx +: 8] <= bus.s_data;
              byte_idx                  <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          bus.checksum <= bus.checksum ^ bus.mem_wdata;
          if (bus.abort)                           state <= IDLE;
          else if (word_idx + 1'b1 == count_q)     state <= FINISH;
          else begin
            word_idx <= word_idx + 1'b1;
            state    <= COLLECT;
          end
        end
        FINISH: begin
          if (!bus.abort) bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream driver, write scoreboard and timing checks.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();
  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-stream driver: presents bq[0] and pops it once the transfer is seen.
  logic [7:0] bq[$];
  bit gap = 0, tog = 0, xfer_seen = 0;
  int acc_cnt = 0, last_xfer_cyc = 0;

  always @(negedge clk) begin
    xfer_seen = !rst && bus.s_valid && bus.s_ready;
    if (xfer_seen) begin
      acc_cnt++;
      last_xfer_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #2;
    if (xfer_seen && bq.size() > 0) void'(bq.pop_front());
    xfer_seen = 0;
    tog = !tog;
    if (bq.size() > 0 && (!gap || tog)) begin
      bus.s_valid = 1'b1;
      bus.s_data  = bq[0];
    end else begin
      bus.s_valid = 1'b0;
    end
  end

  // Write monitor / scoreboard.
  wr_t sb[$];
  int we_cyc[$];
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("write_expected", 32'(sb.size() > 0), 32'd1);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", bus.mem_wdata, e.data);
        end
      end
      if (bus.done)  done_cnt++;
      if (bus.error) err_cnt++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    bus.start      = 1'b1;
    bus.base_addr  = b;
    bus.word_count = c;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int dc);
    bit found;
    found = 0;
    dc    = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        dc    = cyc;
      end
    end
    chk(tag, 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 60 && acc_cnt < n; i++) step(1);
    chk(tag, 32'(acc_cnt >= n), 32'd1);
  endtask

  initial begin : main
    int t0, dc, we0, d0, e0;
    bus.start = 0; bus.abort = 0; bus.base_addr = '0; bus.word_count = '0;
    bus.s_valid = 0; bus.s_data = '0;

    // Reset state
    rst = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_mem_we",  32'(bus.mem_we), 0);
    chk("rst_busy",    32'(bus.busy), 0);
    chk("rst_done",    32'(bus.done), 0);
    chk("rst_error",   32'(bus.error), 0);
    chk("rst_addr",    32'(bus.mem_addr), 0);
    chk("rst_wdata",   bus.mem_wdata, 0);
    chk("rst_cksum",   bus.checksum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Two-word load, back-to-back bytes
    bq = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00};
    sb.push_back('{8'h10, 32'h0000_1000});
    sb.push_back('{8'h11, 32'h0000_2001});
    we_cyc.delete();
    t0 = cyc;
    pulse_start(8'h10, 9'd2);
    wait_done("A_done", 60, dc);
    chk("A_done_cyc", 32'(dc - t0), 32'd12);
    chk("A_we_n", 32'(we_cyc.size()), 32'd2);
    if (we_cyc.size() == 2) begin
      chk("A_we_cyc0", 32'(we_cyc[0] - t0), 32'd5);
      chk("A_we_cyc1", 32'(we_cyc[1] - t0), 32'd10);
    end
    step(1);
    chk("A_cksum", bus.checksum, 32'h0000_3001);
    chk("A_done_cnt", 32'(done_cnt), 32'd1);
    chk("A_busy", 32'(bus.busy), 0);
    chk("A_sb_empty", 32'(sb.size()), 0);

    // Out-of-range start: error pulse, stays idle, checksum cleared
    we0 = we_cnt;
    pulse_start(8'hFF, 9'd2);
    @(negedge clk);
    chk("E_error", 32'(bus.error), 1);
    chk("E_busy", 32'(bus.busy), 0);
    chk("E_s_ready", 32'(bus.s_ready), 0);
    chk("E_cksum", bus.checksum, 0);
    @(negedge clk);
    chk("E_error_pulse", 32'(bus.error), 0);
    chk("E_busy2", 32'(bus.busy), 0);
    step(2);
    chk("E_no_write", 32'(we_cnt - we0), 0);

    // Zero-length load
    t0 = cyc;
    pulse_start(8'h05, 9'd0);
    wait_done("Z_done", 10, dc);
    chk("Z_done_cyc", 32'(dc - t0), 32'd2);
    chk("Z_no_write", 32'(we_cnt - we0), 0);
    chk("Z_cksum", bus.checksum, 0);

    // Gapped stream
    gap = 1;
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sb.push_back('{8'h30, 32'hDEAD_BEEF});
    we0 = we_cnt;
    t0 = cyc;
    pulse_start(8'h30, 9'd1);
    wait_done("G_done", 60, dc);
    chk("G_writes", 32'(we_cnt - we0), 32'd1);
    if (we_cyc.size() > 0) begin
      chk("G_we_after_4th", 32'(we_cyc[$] - last_xfer_cyc), 32'd1);
      chk("G_gapped", 32'((we_cyc[$] - t0) > 5), 32'd1);
    end
    chk("G_cksum", bus.checksum, 32'hDEAD_BEEF);
    gap = 0;
    step(2);

    // Abort after six bytes of a three-word load
    acc_cnt = 0;
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h99, 8'hAA, 8'hBB, 8'hCC};
    sb.push_back('{8'h00, 32'h4433_2211});
    we0 = we_cnt;
    d0  = done_cnt;
    pulse_start(8'h00, 9'd3);
    wait_bytes("B_bytes", 6);
    bus.abort = 1'b1;
    bq.delete();
    step(1);
    bus.abort = 1'b0;
    chk("B_busy", 32'(bus.busy), 0);
    step(8);
    chk("B_writes", 32'(we_cnt - we0), 32'd1);
    chk("B_no_done", 32'(done_cnt - d0), 0);
    chk("B_sb_empty", 32'(sb.size()), 0);
    chk("B_cksum", bus.checksum, 32'h4433_2211);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    sb.push_back('{8'h20, 32'h0403_0201});
    pulse_start(8'h20, 9'd1);
    wait_done("C_done", 40, dc);
    chk("C_cksum", bus.checksum, 32'h0403_0201);
    chk("C_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset during word 1
    acc_cnt = 0;
    bq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    sb.push_back('{8'h40, 32'h4030_2010});
    we0 = we_cnt;
    pulse_start(8'h40, 9'd2);
    wait_bytes("R_bytes", 6);
    rst = 1'b1;
    bq.delete();
    @(negedge clk);
    chk("R_busy", 32'(bus.busy), 0);
    chk("R_s_ready", 32'(bus.s_ready), 0);
    chk("R_mem_we", 32'(bus.mem_we), 0);
    chk("R_addr", 32'(bus.mem_addr), 0);
    chk("R_wdata", bus.mem_wdata, 0);
    chk("R_cksum", bus.checksum, 0);
    chk("R_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(3);
    chk("R_writes", 32'(we_cnt - we0), 32'd1);
    chk("R_sb_empty", 32'(sb.size()), 0);

    // Start while busy is ignored
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    sb.push_back('{8'h50, 32'hD4C3_B2A1});
    we0 = we_cnt;
    d0  = done_cnt;
    e0  = err_cnt;
    pulse_start(8'h50, 9'd1);
    step(1);
    pulse_start(8'h60, 9'd1);
    wait_done("S_done", 40, dc);
    step(4);
    chk("S_writes", 32'(we_cnt - we0), 32'd1);
    chk("S_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("S_no_error", 32'(err_cnt - e0), 0);
    chk("S_busy", 32'(bus.busy), 0);
    chk("S_addr", 32'(bus.mem_addr), 32'h50);
    chk("S_cksum", bus.checksum, 32'hD4C3_B2A1);
    chk("S_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
